// File: rtl/clint_1_12_pkg.sv
// Shared constants and types for the core-local interrupt block.
package clint_1_12_pkg;
  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {IDLE, RESP} bus_state_e;

  // Byte-lane merge: enabled lanes take new data, others keep the old value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] d,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaled 64-bit mtime counter; a half write overrides the tick with no carry.
module clint_mtime_counter
  import clint_1_12_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic        tick,
  output logic [63:0] mtime
);
  logic [15:0] pcnt;

  assign tick = (pcnt == 16'(PRESCALE - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pcnt  <= '0;
      mtime <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 16'd1;
      if (wr_lo)
        mtime[31:0] <= merge_bytes(mtime[31:0], wdata, byte_en);
      else if (wr_hi)
        mtime[63:32] <= merge_bytes(mtime[63:32], wdata, byte_en);
      else if (tick)
        mtime <= mtime + 64'd1;
    end
  end
endmodule

// File: rtl/clint_1_12.sv
// Core-local interruptor: msip/mtime/mtimecmp on a one-wait-state bus slave,
// driving timer, software and synchronised external interrupt levels.
module clint_1_12
  import clint_1_12_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        bus_err,
  input  logic        ext_irq_in,
  output logic        timer_int,
  output logic        soft_int,
  output logic        ext_int
);
  bus_state_e  state, state_nx;
  logic [31:0] addr_q, wdata_q, off, rd_mux;
  logic [3:0]  be_q;
  logic        wr_q;
  logic [63:0] mtimecmp, mtime;
  logic        msip, sync1, sync2, tick;
  logic        hit, sel_msip, sel_clo, sel_chi, sel_tlo, sel_thi, mapped, commit;

  // Decode the latched request; the subtract gives one unsigned window test.
  assign off      = addr_q - BASE_ADDR;
  assign hit      = (off < 32'h0001_0000) && (addr_q[1:0] == 2'b00);
  assign sel_msip = hit && (off[15:0] == MSIP_OFF);
  assign sel_clo  = hit && (off[15:0] == MTIMECMP_LO_OFF);
  assign sel_chi  = hit && (off[15:0] == MTIMECMP_HI_OFF);
  assign sel_tlo  = hit && (off[15:0] == MTIME_LO_OFF);
  assign sel_thi  = hit && (off[15:0] == MTIME_HI_OFF);
  assign mapped   = sel_msip | sel_clo | sel_chi | sel_tlo | sel_thi;
  assign commit   = (state == RESP) && wr_q;

  always_comb begin
    rd_mux = '0;
    if (sel_msip)     rd_mux = {31'd0, msip};
    else if (sel_clo) rd_mux = mtimecmp[31:0];
    else if (sel_chi) rd_mux = mtimecmp[63:32];
    else if (sel_tlo) rd_mux = mtime[31:0];
    else if (sel_thi) rd_mux = mtime[63:32];
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    rdata    = '0;
    bus_err  = 1'b0;
    case (state)
      IDLE: if (ren | wen) begin
        busy     = nRST;
        state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
        bus_err  = !mapped;
        if (!wr_q) rdata = rd_mux;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (ren | wen)) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= byte_en;
        wr_q    <= wen;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mtimecmp  <= MTIMECMP_RESET;
      msip      <= 1'b0;
      timer_int <= 1'b0;
      soft_int  <= 1'b0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
    end else begin
      if (commit && sel_clo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wdata_q, be_q);
      if (commit && sel_chi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata_q, be_q);
      if (commit && sel_msip && be_q[0]) msip <= wdata_q[0];
      timer_int <= (mtime >= mtimecmp);
      soft_int  <= msip;
      sync1     <= ext_irq_in;
      sync2     <= sync1;
    end
  end

  assign ext_int = sync2;

  clint_mtime_counter #(.PRESCALE(PRESCALE)) u_mtime (
    .CLK     (CLK),
    .nRST    (nRST),
    .wr_lo   (commit && sel_tlo),
    .wr_hi   (commit && sel_thi),
    .byte_en (be_q),
    .wdata   (wdata_q),
    .tick    (tick),
    .mtime   (mtime)
  );
endmodule

// File: tb/tb_clint_1_12.sv
// Randomised bench for clint_1_12 against an edge-count based reference model.
module tb_clint_1_12;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          P    = 3;

  logic        CLK = 0, nRST = 0, ren = 0, wen = 0, ext_irq_in = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [3:0]  byte_en = 0;
  logic        busy, bus_err, timer_int, soft_int, ext_int;

  clint_1_12 #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata), .busy(busy), .bus_err(bus_err),
    .ext_irq_in(ext_irq_in), .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int));

  always #5 CLK = ~CLK;

  // Edges since reset release; mtime ticks on every edge k with k % P == 0.
  longint ecnt;
  always @(posedge CLK or negedge nRST)
    if (!nRST) ecnt <= 0;
    else       ecnt <= ecnt + 1;

  int checks = 0, errors = 0;

  // Reference state: mtime = anc_v at edge anc_e plus ticks since then.
  logic [63:0] anc_v, cmp_m;
  longint      anc_e, last_c;
  logic        msip_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mtime_at(input longint n);
    return anc_v + 64'(n / P - anc_e / P);
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? d[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    anc_v = 0; anc_e = 0; last_c = 0; cmp_m = '1; msip_m = 0;
  endtask

  task automatic xact(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    logic [31:0] off, exp_rd;
    logic [63:0] cur;
    logic        ok;
    @(negedge CLK);
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    #1 chk("busy_req", busy, 1);
    @(negedge CLK);
    chk("busy_resp", busy, 0);
    off = a - BASE;
    ok  = (off < 32'h10000) && (a[1:0] == 2'b00) &&
          (off[15:0] inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC});
    cur = mtime_at(ecnt);
    exp_rd = 0;
    if (r && !w && ok)
      case (off[15:0])
        16'h0000: exp_rd = {31'd0, msip_m};
        16'h4000: exp_rd = cmp_m[31:0];
        16'h4004: exp_rd = cmp_m[63:32];
        16'hBFF8: exp_rd = cur[31:0];
        default:  exp_rd = cur[63:32];
      endcase
    chk("rdata", rdata, exp_rd);
    chk("bus_err", bus_err, !ok);
    if (w && ok) begin
      case (off[15:0])
        16'h0000: if (be[0]) msip_m = d[0];
        16'h4000: cmp_m[31:0]  = mrg(cmp_m[31:0], d, be);
        16'h4004: cmp_m[63:32] = mrg(cmp_m[63:32], d, be);
        16'hBFF8: begin anc_v = {cur[63:32], mrg(cur[31:0], d, be)}; anc_e = ecnt + 1; end
        default:  begin anc_v = {mrg(cur[63:32], d, be), cur[31:0]}; anc_e = ecnt + 1; end
      endcase
      last_c = ecnt + 1;
    end
    ren = 0; wen = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (ecnt - 1 >= last_c) begin
        chk("timer_int", timer_int, mtime_at(ecnt - 1) >= cmp_m);
        chk("soft_int", soft_int, msip_m);
      end
    end
  endtask

  initial begin
    logic [31:0] a, rnd;
    bit          seen;
    model_reset();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_ints", {timer_int, soft_int, ext_int}, 0);
    @(negedge CLK); nRST = 1;

    // Free-running mtime after reset
    idle(14);
    xact(1, 0, BASE + 32'hBFF8, 0, 4'hF);
    xact(1, 0, BASE + 32'hBFFC, 0, 4'hF);

    // Timer compare rise and clear
    xact(0, 1, BASE + 32'hBFFC, 0, 4'hF);
    xact(0, 1, BASE + 32'hBFF8, 0, 4'hF);
    xact(0, 1, BASE + 32'h4004, 0, 4'hF);
    xact(0, 1, BASE + 32'h4000, 32'h10, 4'hF);
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      idle(1);
      seen = timer_int;
    end
    chk("timer_rose", seen, 1);
    chk("mtime_at_rise", mtime_at(ecnt - 1), 64'h10);
    xact(0, 1, BASE + 32'h4000, 32'h100, 4'hF);
    idle(2);
    chk("timer_cleared", timer_int, 0);

    // msip
    xact(0, 1, BASE, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    xact(1, 0, BASE, 0, 4'hF);
    xact(0, 1, BASE, 0, 4'hF);
    idle(2);

    // mtime wrap and lo writes at every prescale phase
    xact(0, 1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    xact(0, 1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    idle(8);
    xact(1, 0, BASE + 32'hBFF8, 0, 4'hF);
    xact(1, 0, BASE + 32'hBFFC, 0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      xact(0, 1, BASE + 32'hBFF8, 32'h1234_0000 + i, 4'hF);
      xact(1, 0, BASE + 32'hBFF8, 0, 4'hF);
    end

    // Unmapped and misaligned accesses
    xact(1, 0, BASE + 32'h0008, 0, 4'hF);
    xact(1, 0, BASE + 32'h4001, 0, 4'hF);
    xact(0, 1, BASE + 32'h4001, 32'hDEAD_BEEF, 4'hF);
    xact(0, 1, BASE + 32'h0008, 32'hDEAD_BEEF, 4'hF);
    xact(1, 0, BASE + 32'h4000, 0, 4'hF);
    xact(1, 0, BASE + 32'h4004, 0, 4'hF);

    // External interrupt synchroniser latency
    for (int v = 1; v >= 0; v--) begin
      @(negedge CLK); #2 ext_irq_in = v[0];
      @(negedge CLK); chk("ext_1edge", ext_int, !v[0]);
      @(negedge CLK); chk("ext_2edge", ext_int, v[0]);
    end

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      rnd = $urandom();
      case ($urandom_range(0, 9))
        0: a = BASE;
        1: a = BASE + 32'h4000;
        2: a = BASE + 32'h4004;
        3: a = BASE + 32'hBFF8;
        4: a = BASE + 32'hBFFC;
        5: a = BASE + 32'h0008;
        6: a = BASE + 32'h4001;
        7: a = BASE + {16'd0, rnd[15:2], 2'b00};
        8: a = rnd;
        default: a = rnd[0] ? BASE + 32'h10000 : BASE - 32'd4;
      endcase
      case ($urandom_range(0, 3))
        0, 1: xact(1, 0, a, $urandom(), 4'($urandom()));
        2:    xact(0, 1, a, $urandom(), 4'($urandom()));
        default: xact(1, 1, a, $urandom(), 4'($urandom()));
      endcase
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end

    // Reset during the response cycle of an mtimecmp write
    @(negedge CLK);
    wen = 1; addr = BASE + 32'h4000; wdata = 32'h55; byte_en = 4'hF;
    @(negedge CLK);
    #1 nRST = 0;
    #1 chk("rst_mid_busy", busy, 0);
    wen = 0;
    model_reset();
    @(negedge CLK); nRST = 1;
    xact(1, 0, BASE + 32'h4000, 0, 4'hF);
    xact(1, 0, BASE + 32'h4004, 0, 4'hF);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
